// File: rtl/rle_code_stack.sv
// rle_code_stack: frame-gated LIFO codeword buffer feeding the RLE decoder.
// Loads one frame in encoder order, then presents it last-in-first-out.
module rle_code_stack #(
   parameter int DEPTH   = 16,
   parameter int WIDTH   = 8,
   parameter int CW_BASE = 32
) (
   input  logic                   sclk,
   input  logic                   rst,
   input  logic                   pushValid,
   input  logic [WIDTH-1:0]       pushData,
   input  logic                   pushLast,
   output logic                   pushReady,
   input  logic                   read,
   output logic                   stackEmpty,
   output logic [WIDTH-1:0]       codeWord,
   output logic [$clog2(DEPTH):0] level,
   output logic                   frameDone,
   output logic                   badCode,
   output logic                   underflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t           state_q;
   logic [LW-1:0]    level_q;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             frame_done_q;
   logic             bad_code_q;
   logic             underflow_q;

   logic             push_go;
   logic             pop_go;
   logic [LW-1:0]    top;

   assign pushReady  = (state_q != DRAIN) && (level_q < LW'(DEPTH));
   assign stackEmpty = !((state_q == DRAIN) && (level_q != '0));
   assign top        = level_q - LW'(1);
   // Decoder samples codeWord in the same cycle it pops, so keep it combinational.
   assign codeWord   = stackEmpty ? '0 : mem_q[top[AW-1:0]];

   assign push_go = pushValid && pushReady;
   assign pop_go  = read && !stackEmpty;

   assign level     = level_q;
   assign frameDone = frame_done_q;
   assign badCode   = bad_code_q;
   assign underflow = underflow_q;

   always_ff @(posedge sclk) begin
      if (push_go) begin
         mem_q[level_q[AW-1:0]] <= pushData;
      end
   end

   always_ff @(posedge sclk) begin
      if (!rst) begin
         state_q      <= IDLE;
         level_q      <= '0;
         frame_done_q <= 1'b0;
         bad_code_q   <= 1'b0;
         underflow_q  <= 1'b0;
      end else begin
         frame_done_q <= 1'b0;
         if (read && stackEmpty) begin
            underflow_q <= 1'b1;
         end
         unique case (state_q)
            IDLE, FILL: begin
               if (push_go) begin
                  level_q <= level_q + LW'(1);
                  state_q <= pushLast ? DRAIN : FILL;
                  if (pushData < WIDTH'(CW_BASE)) begin
                     bad_code_q <= 1'b1;
                  end
               end
            end
            DRAIN: begin
               if (pop_go) begin
                  level_q <= level_q - LW'(1);
                  if (level_q == LW'(1)) begin
                     state_q      <= IDLE;
                     frame_done_q <= 1'b1;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rle_code_stack.sv
// tb_rle_code_stack: directed self-checking bench for rle_code_stack.
// Inputs change #1 after a rising edge; outputs are checked there too.
module tb_rle_code_stack;

   logic       sclk = 1'b0;
   logic       rst;
   logic       pushValid;
   logic [7:0] pushData;
   logic       pushLast;
   logic       pushReady;
   logic       read;
   logic       stackEmpty;
   logic [7:0] codeWord;
   logic [4:0] level;
   logic       frameDone;
   logic       badCode;
   logic       underflow;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 sclk = ~sclk;

   rle_code_stack #(.DEPTH(16), .WIDTH(8), .CW_BASE(32)) dut (
      .sclk      (sclk),
      .rst       (rst),
      .pushValid (pushValid),
      .pushData  (pushData),
      .pushLast  (pushLast),
      .pushReady (pushReady),
      .read      (read),
      .stackEmpty(stackEmpty),
      .codeWord  (codeWord),
      .level     (level),
      .frameDone (frameDone),
      .badCode   (badCode),
      .underflow (underflow)
   );

   task automatic tick();
      @(posedge sclk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b0;
      tick();
      rst = 1'b1;
   endtask

   task automatic push(input logic [7:0] d, input logic last);
      pushValid = 1'b1;
      pushData  = d;
      pushLast  = last;
      tick();
      pushValid = 1'b0;
      pushLast  = 1'b0;
   endtask

   task automatic pop(input string tag, input logic [7:0] exp);
      chk(tag, {24'd0, codeWord}, {24'd0, exp});
      read = 1'b1;
      tick();
      read = 1'b0;
   endtask

   initial begin
      rst = 1'b1; pushValid = 1'b0; pushData = '0;
      pushLast = 1'b0; read = 1'b0;
      tick();
      do_reset();
      chk("rst_level", level, 0);
      chk("rst_ready", pushReady, 1);
      chk("rst_empty", stackEmpty, 1);
      chk("rst_cw", codeWord, 0);
      chk("rst_fd", frameDone, 0);
      chk("rst_bad", badCode, 0);
      chk("rst_uf", underflow, 0);

      // Test 1: basic LIFO frame
      push(8'h23, 1'b0);
      chk("t1_empty_fill", stackEmpty, 1);
      push(8'h21, 1'b0);
      push(8'h25, 1'b1);
      chk("t1_ready", pushReady, 0);
      chk("t1_empty", stackEmpty, 0);
      chk("t1_level3", level, 3);
      pop("t1_cw0", 8'h25);
      chk("t1_level2", level, 2);
      pop("t1_cw1", 8'h21);
      chk("t1_fd_early", frameDone, 0);
      pop("t1_cw2", 8'h23);
      chk("t1_level0", level, 0);
      chk("t1_fd", frameDone, 1);
      chk("t1_empty_end", stackEmpty, 1);
      chk("t1_ready_end", pushReady, 1);
      tick();
      chk("t1_fd_once", frameDone, 0);
      chk("t1_uf", underflow, 0);

      // Test 2: read during FILL is ignored
      push(8'h30, 1'b0);
      push(8'h31, 1'b0);
      read = 1'b1;
      tick();
      read = 1'b0;
      chk("t2_level", level, 2);
      chk("t2_empty", stackEmpty, 1);
      chk("t2_uf", underflow, 1);
      push(8'h32, 1'b1);
      pop("t2_cw0", 8'h32);
      pop("t2_cw1", 8'h31);
      pop("t2_cw2", 8'h30);
      chk("t2_fd", frameDone, 1);
      chk("t2_uf_sticky", underflow, 1);

      // Test 3a: full frame with last on the 16th
      do_reset();
      for (int i = 0; i < 16; i++) begin
         chk("t3_ready_each", pushReady, 1);
         push(8'(8'h20 + i), i == 15);
      end
      chk("t3_level16", level, 16);
      chk("t3_ready_drain", pushReady, 0);
      for (int i = 15; i >= 0; i--) begin
         pop("t3_cw", 8'(8'h20 + i));
      end
      chk("t3_fd", frameDone, 1);
      chk("t3_level0", level, 0);

      // Test 3b: 16 without last stalls, 17th held
      for (int i = 0; i < 16; i++) begin
         push(8'(8'h40 + i), 1'b0);
      end
      chk("t3b_level", level, 16);
      chk("t3b_ready", pushReady, 0);
      pushValid = 1'b1;
      pushData  = 8'h01;
      tick();
      tick();
      pushValid = 1'b0;
      chk("t3b_held", level, 16);
      chk("t3b_bad", badCode, 0);
      chk("t3b_uf", underflow, 0);
      chk("t3b_empty", stackEmpty, 1);

      // Test 4: bad codeword still stored
      do_reset();
      push(8'h1F, 1'b1);
      chk("t4_bad", badCode, 1);
      chk("t4_empty", stackEmpty, 0);
      pop("t4_cw", 8'h1F);
      chk("t4_fd", frameDone, 1);
      tick();
      chk("t4_bad_sticky", badCode, 1);

      // Test 5: single-entry frame at CW_BASE
      push(8'h20, 1'b1);
      chk("t5_level", level, 1);
      chk("t5_empty", stackEmpty, 0);
      chk("t5_ready", pushReady, 0);
      pop("t5_cw", 8'h20);
      chk("t5_fd", frameDone, 1);
      chk("t5_empty_end", stackEmpty, 1);
      chk("t5_bad_sticky", badCode, 1);

      // Test 6: reset mid-DRAIN
      read = 1'b1;
      tick();
      read = 1'b0;
      chk("t6_uf_pre", underflow, 1);
      for (int i = 0; i < 5; i++) begin
         push(8'(8'h50 + i), i == 4);
      end
      chk("t6_level5", level, 5);
      chk("t6_cw5", codeWord, 8'h54);
      do_reset();
      chk("t6_level", level, 0);
      chk("t6_empty", stackEmpty, 1);
      chk("t6_ready", pushReady, 1);
      chk("t6_cw", codeWord, 0);
      chk("t6_bad", badCode, 0);
      chk("t6_uf", underflow, 0);
      chk("t6_fd", frameDone, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/rle_code_stack.md
Name: rle_code_stack

Overview:
- LIFO codeword buffer directly upstream of the RLE decoder.
- Upstream loads one frame of 8-bit run-length codewords (run length + 32) in encoder order.
- Once the frame is committed, the block presents codewords last-in-first-out on the decoder's `stackEmpty`/`codeWord`/`read` interface until the frame is drained.
- Frame gating keeps the decoder from popping a partially loaded frame.

Parameters:
- DEPTH, 16, number of codeword entries (power of two, 2..256).
- WIDTH, 8, codeword width in bits.
- CW_BASE, 32, smallest legal codeword value (run length 0).

Ports:
- sclk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-low reset.
- pushValid  input  1  upstream offers a codeword.
- pushData  input  WIDTH  codeword offered.
- pushLast  input  1  qualifies pushData as the final codeword of the frame.
- pushReady  output  1  block accepts pushData this cycle.
- read  input  1  decoder pop strobe, one cycle.
- stackEmpty  output  1  no codeword available to decoder.
- codeWord  output  WIDTH  top-of-stack codeword, combinational.
- level  output  clog2(DEPTH)+1  entries currently stored.
- frameDone  output  1  one-cycle pulse after the last pop of a frame.
- badCode  output  1  sticky: a codeword below CW_BASE was accepted.
- underflow  output  1  sticky: read seen while no codeword was presented.

Behaviour:
- Reset (rst low at a rising edge):
  - state=IDLE, level=0, all flags 0.
  - pushReady=1, stackEmpty=1, codeWord=0.
  - Reset mid-frame discards all contents.
- States:
  - IDLE: stack empty, no frame in progress.
  - FILL: at least one codeword pushed, frame not yet committed.
  - DRAIN: frame committed, decoder popping.
- Push handshake:
  - A transfer occurs on a rising edge with pushValid=1 and pushReady=1.
  - pushReady = (state!=DRAIN) && (level<DEPTH).
  - A transfer writes mem[level] <= pushData and level <= level+1.
  - pushValid with pushReady low causes no transfer and no error; upstream holds its data.
- Transitions:
  - IDLE->FILL on a transfer with pushLast=0.
  - IDLE->DRAIN or FILL->DRAIN on a transfer with pushLast=1, so a single-entry frame is legal.
  - DRAIN->IDLE on the pop that takes level from 1 to 0; that same edge sets frameDone=1 for exactly the next cycle.
  - A full stack in FILL stalls (pushReady=0) until reset. Upstream must size frames to at most DEPTH; the last codeword may fill the stack exactly.
- Decoder side:
  - stackEmpty = !(state==DRAIN && level>0).
  - codeWord = mem[level-1] when stackEmpty=0, else 0.
  - The decoder samples codeWord in the same cycle it asserts read, so codeWord must be valid combinationally whenever stackEmpty=0.
  - A pop occurs on a rising edge with read=1 and stackEmpty=0: level <= level-1.
  - read with stackEmpty=1 (including during IDLE/FILL) is ignored and sets underflow.
- Simultaneous push and pop cannot occur by construction: push only in IDLE/FILL, pop only in DRAIN.
- Code checking: a transfer with pushData < CW_BASE is still stored and sets badCode. The decoder's subtraction would wrap, so software must treat badCode as a fatal frame error.
- Sticky flags (badCode, underflow) clear only on reset.
- level always equals pushes minus pops since reset or the last return to IDLE; it never wraps.

Test Plan:
1. Reset, then push 0x23, 0x21, 0x25(last) -> pushReady=0 after the third transfer; stackEmpty falls the cycle after; codeWord sequence on successive reads is 0x25, 0x21, 0x23; level 3->0; frameDone pulses once; state IDLE; pushReady=1.
2. During FILL (2 entries), assert read -> no pop, level stays 2, stackEmpty=1, underflow=1; complete the frame and drain normally.
3. DEPTH=16: push 16 codewords with pushLast on the 16th -> all accepted, pushReady=0 in DRAIN. Separately push 16 without last -> pushReady=0, a 17th pushValid is held with level=16 and no error.
4. Push 0x1F(last) -> badCode=1, codeWord=0x1F presented, badCode stays 1 after the drain.
5. Single-entry frame 0x20(last) -> IDLE->DRAIN directly; one read returns 0x20; frameDone the next cycle.
6. Assert rst low mid-DRAIN with level=5 -> next cycle level=0, stackEmpty=1, flags cleared, pushReady=1.
